// File: rtl/alu_regfile_datapath.sv
// Execute datapath: 8x8 register file with combinational reads and an
// 8-bit ALU whose result is written back at the rising clock edge.
module alu_regfile_datapath #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [ADDR_WIDTH-1:0] READREG1,
   input  logic [ADDR_WIDTH-1:0] READREG2,
   input  logic [ADDR_WIDTH-1:0] WRITEREG,
   input  logic                  WRITEENABLE,
   input  logic [2:0]            ALUOP,
   input  logic [DATA_WIDTH-1:0] OPERAND2,
   output logic [DATA_WIDTH-1:0] REGOUT1,
   output logic [DATA_WIDTH-1:0] REGOUT2,
   output logic [DATA_WIDTH-1:0] ALURESULT
);

   localparam int NREG = 1 << ADDR_WIDTH;

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;

   logic [DATA_WIDTH-1:0] regs [NREG];

   // Reset takes priority over a pending write-back
   always_ff @(posedge CLK) begin
      if (RESET) begin
         regs <= '{default: '0};
      end else if (WRITEENABLE) begin
         regs[WRITEREG] <= ALURESULT;
      end
   end

   assign REGOUT1 = regs[READREG1];
   assign REGOUT2 = regs[READREG2];

   always_comb begin
      ALURESULT = '0;
      unique case (ALUOP)
         OP_FWD:  ALURESULT = OPERAND2;
         OP_ADD:  ALURESULT = REGOUT1 + OPERAND2;
         OP_AND:  ALURESULT = REGOUT1 & OPERAND2;
         OP_OR:   ALURESULT = REGOUT1 | OPERAND2;
         default: ALURESULT = '0;
      endcase
   end

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Randomised and directed checks of alu_regfile_datapath against
// an array-based reference model of the register file and ALU.
module tb_alu_regfile_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] rr1, rr2, wr;
   logic       we;
   logic [2:0] op;
   logic [7:0] op2;
   logic [7:0] out1, out2, res;

   int n_tests = 0;
   int n_fail  = 0;
   int m [8];

   always #5 clk = ~clk;

   alu_regfile_datapath dut (
      .CLK         (clk),
      .RESET       (rst),
      .READREG1    (rr1),
      .READREG2    (rr2),
      .WRITEREG    (wr),
      .WRITEENABLE (we),
      .ALUOP       (op),
      .OPERAND2    (op2),
      .REGOUT1     (out1),
      .REGOUT2     (out2),
      .ALURESULT   (res)
   );

   function automatic int alu_ref(int o, int a, int b);
      case (o)
         0: return b;
         1: return (a + b) % 256;
         2: return a & b;
         3: return a | b;
         default: return 0;
      endcase
   endfunction

   task automatic check(string tag, int got, int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
      end
   endtask

   task automatic drive(bit r, bit w, int a1, int a2,
                        int d, int o, int b);
      rst = r;
      we  = w;
      rr1 = 3'(a1);
      rr2 = 3'(a2);
      wr  = 3'(d);
      op  = 3'(o);
      op2 = 8'(b);
      #1;
   endtask

   task automatic check_model(string tag);
      check({tag, "_r1"}, int'(out1), m[rr1]);
      check({tag, "_r2"}, int'(out2), m[rr2]);
      check({tag, "_res"}, int'(res),
            alu_ref(op, m[rr1], op2));
   endtask

   task automatic tick();
      int v;
      v = alu_ref(op, m[rr1], op2);
      @(posedge clk);
      if (rst) begin
         foreach (m[i]) m[i] = 0;
      end else if (we) begin
         m[wr] = v;
      end
      #1;
   endtask

   initial begin
      foreach (m[i]) m[i] = 0;
      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      tick();

      for (int i = 0; i < 8; i++) begin
         drive(0, 0, i, 7 - i, 0, 0, 0);
         check("rst_r1", int'(out1), 0);
         check("rst_r2", int'(out2), 0);
      end

      drive(0, 1, 4, 0, 4, 0, 8'h05);
      tick();
      drive(0, 1, 4, 0, 6, 0, 8'h09);
      check("ld_r4", int'(out1), 8'h05);
      tick();

      drive(0, 1, 4, 6, 0, 1, 8'h09);
      check("add", int'(res), 8'h0E);
      tick();
      drive(0, 0, 0, 6, 0, 0, 0);
      check("add_wb", int'(out1), 8'h0E);

      drive(0, 1, 0, 0, 1, 0, 8'hFF);
      tick();
      drive(0, 0, 1, 0, 0, 1, 8'h02);
      check("add_wrap", int'(res), 8'h01);
      drive(0, 0, 4, 0, 0, 1, 8'hF7);
      check("sub", int'(res), 8'hFC);

      drive(0, 1, 0, 0, 2, 0, 8'hF0);
      tick();
      drive(0, 0, 2, 0, 0, 2, 8'h3C);
      check("and", int'(res), 8'h30);
      drive(0, 0, 2, 0, 0, 3, 8'h0F);
      check("or", int'(res), 8'hFF);
      drive(0, 0, 2, 0, 0, 5, 8'h0F);
      check("rsvd", int'(res), 8'h00);

      drive(0, 0, 4, 0, 4, 0, 8'h77);
      tick();
      check("we0", int'(out1), 8'h05);

      drive(0, 1, 3, 3, 3, 0, 8'hA5);
      check("rdw_old1", int'(out1), m[3]);
      check("rdw_old2", int'(out2), m[3]);
      tick();
      check("rdw_new1", int'(out1), 8'hA5);
      check("rdw_new2", int'(out2), 8'hA5);

      drive(1, 1, 0, 0, 5, 0, 8'h5A);
      tick();
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, i, i, 0, 0, 0);
         check("rst2", int'(out1), 0);
      end
      drive(0, 1, 0, 0, 5, 0, 8'h3D);
      tick();
      drive(0, 0, 5, 0, 0, 0, 0);
      check("resume", int'(out1), 8'h3D);

      for (int k = 0; k < 400; k++) begin
         int o, a1, a2, b, sel;
         bit r, w;
         o   = int'($urandom_range(0, 7));
         a1  = int'($urandom_range(0, 7));
         a2  = int'($urandom_range(0, 7));
         sel = int'($urandom_range(0, 2));
         r   = ($urandom_range(0, 31) == 0);
         w   = (o < 4) && ($urandom_range(0, 3) != 0);
         case (sel)
            0: b = m[a2];
            1: b = (256 - m[a2]) % 256;
            default: b = int'($urandom_range(0, 255));
         endcase
         drive(r, w, a1, a2, int'($urandom_range(0, 7)), o, b);
         check_model("rnd");
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
